// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter and fixed-latency access sequencer.
// Three requesters (fetch, data, I/O) share one 4096x16 memory. One access is
// in flight at a time: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> ACK.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_we,
  input  logic [35:0] i_addr,
  input  logic [47:0] i_wdata,
  output logic [2:0]  o_gnt,
  output logic [2:0]  o_ack,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t      state;
  logic [3:0]  starve;
  logic [2:0]  lat_cnt;
  logic        lat_we;

  logic [2:0]  sel;
  logic        sel_we;
  logic [11:0] sel_addr;
  logic [15:0] sel_wdata;

  // Pick the winner among current requests and mux out its access fields.
  always_comb begin
    sel       = 3'b000;
    sel_we    = 1'b0;
    sel_addr  = 12'h000;
    sel_wdata = 16'h0000;
    if (i_req[2] && (starve == STARVE_MAX)) sel = 3'b100;
    else if (i_req[1])                      sel = 3'b010;
    else if (i_req[0])                      sel = 3'b001;
    else if (i_req[2])                      sel = 3'b100;
    case (sel)
      3'b001: begin
        sel_we    = i_we[0];
        sel_addr  = i_addr[11:0];
        sel_wdata = i_wdata[15:0];
      end
      3'b010: begin
        sel_we    = i_we[1];
        sel_addr  = i_addr[23:12];
        sel_wdata = i_wdata[31:16];
      end
      3'b100: begin
        sel_we    = i_we[2];
        sel_addr  = i_addr[35:24];
        sel_wdata = i_wdata[47:32];
      end
      default: ;
    endcase
  end

  // Access sequencer FSM with registered grant/ack/strobes and starve tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      starve    <= 4'd0;
      lat_cnt   <= 3'd0;
      lat_we    <= 1'b0;
      o_gnt     <= 3'b000;
      o_ack     <= 3'b000;
      o_rdata   <= 16'h0000;
      o_busy    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 12'h000;
      mem_wdata <= 16'h0000;
    end else begin
      o_ack  <= 3'b000;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          // I/O idle or just served: forget the losses; otherwise count one.
          if (!i_req[2] || sel[2]) starve <= 4'd0;
          else if (starve != STARVE_MAX) starve <= starve + 4'd1;
          if (|i_req) begin
            state     <= ACCESS;
            o_gnt     <= sel;
            o_busy    <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            lat_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          state   <= WAIT;
          lat_cnt <= LAT_LOAD;
        end
        WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= ACK;
            o_ack <= o_gnt;
            if (!lat_we) o_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          o_gnt  <= 3'b000;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter with MEM_LAT=1 (u1) and
// MEM_LAT=3 (u3) instances, each with its own behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u1 signals (MEM_LAT=1)
  logic [2:0]  req1 = '0, we1 = '0;
  logic [35:0] addr1 = '0;
  logic [47:0] wdata1 = '0;
  logic [2:0]  gnt1, ack1;
  logic [15:0] rdata1, mwdata1, mrdata1;
  logic        busy1, men1, mwe1;
  logic [11:0] maddr1;

  // u3 signals (MEM_LAT=3)
  logic [2:0]  req3 = '0, we3 = '0;
  logic [35:0] addr3 = '0;
  logic [47:0] wdata3 = '0;
  logic [2:0]  gnt3, ack3;
  logic [15:0] rdata3, mwdata3, mrdata3;
  logic        busy3, men3, mwe3;
  logic [11:0] maddr3;

  mem_arbiter #(.MEM_LAT(1), .STARVE_LIM(4)) u1 (
    .clk(clk), .reset_n(reset_n), .i_req(req1), .i_we(we1), .i_addr(addr1),
    .i_wdata(wdata1), .o_gnt(gnt1), .o_ack(ack1), .o_rdata(rdata1), .o_busy(busy1),
    .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwdata1),
    .mem_rdata(mrdata1));

  mem_arbiter #(.MEM_LAT(3), .STARVE_LIM(4)) u3 (
    .clk(clk), .reset_n(reset_n), .i_req(req3), .i_we(we3), .i_addr(addr3),
    .i_wdata(wdata3), .o_gnt(gnt3), .o_ack(ack3), .o_rdata(rdata3), .o_busy(busy3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3), .mem_wdata(mwdata3),
    .mem_rdata(mrdata3));

  // Behavioural memories; read data is only valid exactly MEM_LAT cycles
  // after the strobe, otherwise 16'hDEAD is presented.
  logic [15:0] mem1 [0:4095];
  logic [15:0] mem3 [0:4095];
  logic [15:0] p1_0 = 16'hDEAD;
  logic [15:0] p3_0 = 16'hDEAD, p3_1 = 16'hDEAD, p3_2 = 16'hDEAD;
  logic        pl_we = 1'b0, pl_sel = 1'b0;
  logic [11:0] pl_a = '0;
  logic [15:0] pl_d = '0;

  assign mrdata1 = p1_0;
  assign mrdata3 = p3_2;

  always @(posedge clk) begin
    if (pl_we && !pl_sel) mem1[pl_a] <= pl_d;
    else if (men1 && mwe1) mem1[maddr1] <= mwdata1;
    p1_0 <= (men1 && !mwe1) ? mem1[maddr1] : 16'hDEAD;
  end

  always @(posedge clk) begin
    if (pl_we && pl_sel) mem3[pl_a] <= pl_d;
    else if (men3 && mwe3) mem3[maddr3] <= mwdata3;
    p3_0 <= (men3 && !mwe3) ? mem3[maddr3] : 16'hDEAD;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic which, input logic [11:0] a, input logic [15:0] d);
    pl_sel = which; pl_a = a; pl_d = d; pl_we = 1'b1;
    step();
    pl_we = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (gnt1 !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b want 000", gnt1); end
    checks++; if (ack1 !== 3'b000) begin errors++; $display("FAIL rst_ack: got %b want 000", ack1); end
    checks++; if ({busy1, men1, mwe1} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {busy1, men1, mwe1}); end
    checks++; if (rdata1 !== 16'h0000) begin errors++; $display("FAIL rst_rdata: got %h want 0000", rdata1); end
    checks++; if ({maddr1, mwdata1} !== 28'h0) begin errors++; $display("FAIL rst_maddr_wdata: got %h want 0", {maddr1, mwdata1}); end
    reset_n = 1'b1;
    step();
    preload(1'b0, 12'h010, 16'h7800);
    preload(1'b0, 12'h020, 16'h1111);
    preload(1'b0, 12'h040, 16'h4242);
    preload(1'b0, 12'h050, 16'h0F0F);
    preload(1'b1, 12'h0FF, 16'hA5C3);
  endtask

  task automatic test_fetch_read();
    req1 = 3'b001; we1 = 3'b000; addr1 = {24'h0, 12'h010};
    step();  // t+1 ACCESS
    checks++; if ({men1, mwe1} !== 2'b10) begin errors++; $display("FAIL fetch_strobe: got %b want 10", {men1, mwe1}); end
    checks++; if (maddr1 !== 12'h010) begin errors++; $display("FAIL fetch_addr: got %h want 010", maddr1); end
    checks++; if ({gnt1, busy1} !== 4'b0011) begin errors++; $display("FAIL fetch_gnt_busy: got %b want 0011", {gnt1, busy1}); end
    step();  // t+2 WAIT
    checks++; if ({men1, ack1} !== 4'b0000) begin errors++; $display("FAIL fetch_wait: got %b want 0000", {men1, ack1}); end
    step();  // t+3 ACK
    checks++; if (ack1 !== 3'b001) begin errors++; $display("FAIL fetch_ack: got %b want 001", ack1); end
    checks++; if (rdata1 !== 16'h7800) begin errors++; $display("FAIL fetch_rdata: got %h want 7800", rdata1); end
    req1 = 3'b000;
    step();  // IDLE
    checks++; if ({gnt1, ack1, busy1} !== 7'b0) begin errors++; $display("FAIL fetch_idle: got %b want 0000000", {gnt1, ack1, busy1}); end
    step();
    checks++; if (men1 !== 1'b0) begin errors++; $display("FAIL fetch_no_reaccess: got %b want 0", men1); end
  endtask

  task automatic test_priority_write();
    req1 = 3'b011; we1 = 3'b010;
    addr1 = {12'h0, 12'h123, 12'h020};
    wdata1 = {16'h0, 16'hBEEF, 16'h5555};
    step();  // data ACCESS
    checks++; if (gnt1 !== 3'b010) begin errors++; $display("FAIL prio_gnt_data: got %b want 010", gnt1); end
    checks++; if ({men1, mwe1, maddr1, mwdata1} !== {2'b11, 12'h123, 16'hBEEF}) begin errors++; $display("FAIL prio_write_bus: got %h want %h", {men1, mwe1, maddr1, mwdata1}, {2'b11, 12'h123, 16'hBEEF}); end
    step(); step();  // ACK
    checks++; if (ack1 !== 3'b010) begin errors++; $display("FAIL prio_ack_data: got %b want 010", ack1); end
    checks++; if (rdata1 !== 16'h7800) begin errors++; $display("FAIL prio_rdata_kept: got %h want 7800", rdata1); end
    checks++; if (mem1[12'h123] !== 16'hBEEF) begin errors++; $display("FAIL prio_mem_written: got %h want BEEF", mem1[12'h123]); end
    req1 = 3'b001;
    step();  // IDLE, fetch sampled
    checks++; if (gnt1 !== 3'b000) begin errors++; $display("FAIL prio_idle_gap: got %b want 000", gnt1); end
    step();  // fetch ACCESS
    checks++; if ({gnt1, mwe1, maddr1} !== {3'b001, 1'b0, 12'h020}) begin errors++; $display("FAIL prio_gnt_fetch: got %h want %h", {gnt1, mwe1, maddr1}, {3'b001, 1'b0, 12'h020}); end
    step(); step();  // ACK
    checks++; if ({ack1, rdata1} !== {3'b001, 16'h1111}) begin errors++; $display("FAIL prio_fetch_ack: got %h want %h", {ack1, rdata1}, {3'b001, 16'h1111}); end
    req1 = 3'b000;
    step();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g;
    req1 = 3'b110; we1 = 3'b110;
    addr1 = {12'h300, 12'h200, 12'h000};
    wdata1 = {16'h3333, 16'h2222, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      exp_g = (i == 4 || i == 9) ? 3'b100 : 3'b010;
      step();
      checks++; if (gnt1 !== exp_g) begin errors++; $display("FAIL starve_gnt_%0d: got %b want %b", i, gnt1, exp_g); end
      step(); step();
      checks++; if (ack1 !== exp_g) begin errors++; $display("FAIL starve_ack_%0d: got %b want %b", i, ack1, exp_g); end
      if (i == 9) req1 = 3'b000;
      step();
    end
    checks++; if (mem1[12'h300] !== 16'h3333) begin errors++; $display("FAIL starve_io_write: got %h want 3333", mem1[12'h300]); end
  endtask

  task automatic test_latency3();
    req3 = 3'b010; we3 = 3'b000; addr3 = {12'h0, 12'h0FF, 12'h0};
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (ack3 !== ((k == 5) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL lat3_ack_k%0d: got %b want %b", k, ack3, (k == 5) ? 3'b010 : 3'b000); end
      checks++; if (men3 !== (k == 1)) begin errors++; $display("FAIL lat3_en_k%0d: got %b want %b", k, men3, (k == 1)); end
      if (k <= 5) begin
        checks++; if (maddr3 !== 12'h0FF) begin errors++; $display("FAIL lat3_addr_k%0d: got %h want 0FF", k, maddr3); end
      end
      if (k == 5) begin
        checks++; if (rdata3 !== 16'hA5C3) begin errors++; $display("FAIL lat3_rdata: got %h want A5C3", rdata3); end
        req3 = 3'b000;
      end
    end
  endtask

  task automatic test_reset_mid();
    req1 = 3'b001; we1 = 3'b000; addr1 = {24'h0, 12'h040};
    step(); step();  // in WAIT
    reset_n = 1'b0;
    #1;
    checks++; if ({gnt1, ack1, busy1, men1, mwe1} !== 9'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b want 0", {gnt1, ack1, busy1, men1, mwe1}); end
    checks++; if ({rdata1, maddr1} !== 28'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", {rdata1, maddr1}); end
    step();
    checks++; if ({ack1, men1} !== 4'b0) begin errors++; $display("FAIL rstmid_held: got %b want 0000", {ack1, men1}); end
    reset_n = 1'b1;
    step();  // re-served from scratch: ACCESS
    checks++; if ({gnt1, men1, maddr1} !== {3'b001, 1'b1, 12'h040}) begin errors++; $display("FAIL rstmid_reserve: got %h want %h", {gnt1, men1, maddr1}, {3'b001, 1'b1, 12'h040}); end
    step(); step();
    checks++; if ({ack1, rdata1} !== {3'b001, 16'h4242}) begin errors++; $display("FAIL rstmid_ack: got %h want %h", {ack1, rdata1}, {3'b001, 16'h4242}); end
    req1 = 3'b000;
    step();
  endtask

  task automatic test_drop_early();
    req1 = 3'b001; we1 = 3'b000; addr1 = {24'h0, 12'h050};
    step();  // ACCESS
    req1 = 3'b000;
    step(); step();  // ACK
    checks++; if ({ack1, rdata1} !== {3'b001, 16'h0F0F}) begin errors++; $display("FAIL drop_ack: got %h want %h", {ack1, rdata1}, {3'b001, 16'h0F0F}); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({men1, gnt1, busy1} !== 5'b0) begin errors++; $display("FAIL drop_no_second_%0d: got %b want 00000", k, {men1, gnt1, busy1}); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_priority_write();
    test_starvation();
    test_latency3();
    test_reset_mid();
    test_drop_early();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
